spi_oled_fb: RTL and testbench

SPI_OLED_FB -- requirements
Module: spi_oled_fb

---
 rtl/spi_oled_fb.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_oled_fb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_oled_fb.sv
`default_nettype none
// spi_oled_fb: SPI-loaded OLED framebuffer with SSD1306-style page/horizontal cursor commands. Rev 1.0
// Define SPI_OLED_FB_MIRROR_EN to store the image rotated 180 degrees (address and bit order reversed).
module spi_oled_fb #(
  parameter int COLS  = 128,
  parameter int PAGES = 8,
  localparam int CW = $clog2(COLS),
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          spi_clk,
  input  logic          spi_din,
  input  logic          spi_cs,
  input  logic          spi_cd,
  input  logic [CW-1:0] rd_col,
  input  logic [PW-1:0] rd_page,
  output logic [7:0]    rd_data,
  output logic          wr_strobe,
  output logic [CW-1:0] cur_col,
  output logic [PW-1:0] cur_page
);

  localparam int AW    = PW + CW;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARG_MODE = 3'd1,
    ST_ARG_CS   = 3'd2,
    ST_ARG_CE   = 3'd3,
    ST_ARG_PS   = 3'd4,
    ST_ARG_PE   = 3'd5
  } state_t;

  logic [1:0]    sclk_s_q, sclk_s_d;
  logic [1:0]    din_s_q, din_s_d;
  logic [1:0]    cs_s_q, cs_s_d;
  logic [1:0]    cd_s_q, cd_s_d;
  logic          sclk_prev_q, sclk_prev_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  state_t        state_q, state_d;
  logic          horiz_q, horiz_d;
  logic [CW-1:0] col_start_q, col_start_d;
  logic [CW-1:0] col_end_q, col_end_d;
  logic [PW-1:0] page_start_q, page_start_d;
  logic [PW-1:0] page_end_q, page_end_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [PW-1:0] cur_page_q, cur_page_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [7:0]    rd_data_q;

  logic          sclk_rise;
  logic          byte_done;
  logic [7:0]    byte_in;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [7:0]    fb_wdata;
  logic [PW-1:0] page_next;

  logic [7:0]    fb [DEPTH];

  always_comb begin
    sclk_s_d    = {sclk_s_q[0], spi_clk};
    din_s_d     = {din_s_q[0], spi_din};
    cs_s_d      = {cs_s_q[0], spi_cs};
    cd_s_d      = {cd_s_q[0], spi_cd};
    sclk_prev_d = sclk_s_q[1];

    sclk_rise = sclk_s_q[1] & ~sclk_prev_q;
    byte_done = sclk_rise & ~cs_s_q[1] & (bit_cnt_q == 3'd7);
    byte_in   = {shift_q[6:0], din_s_q[1]};
    page_next = (cur_page_q + 1'b1) & PW'(PAGES - 1);

    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    state_d      = state_q;
    horiz_d      = horiz_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    cur_col_d    = cur_col_q;
    cur_page_d   = cur_page_q;
    wr_strobe_d  = 1'b0;
    fb_we        = 1'b0;

    // Deselect throws away any partial byte; everything above the shifter is kept.
    if (cs_s_q[1]) begin
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
    end else if (sclk_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = byte_in;
    end

    if (byte_done) begin
      if (cd_s_q[1]) begin
        fb_we       = 1'b1;
        wr_strobe_d = 1'b1;
        if (horiz_q && (cur_col_q == col_end_q)) begin
          cur_col_d  = col_start_q;
          cur_page_d = (cur_page_q == page_end_q) ? page_start_q : page_next;
        end else begin
          cur_col_d = cur_col_q + 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_in[7:4] == 4'h0) begin
              cur_col_d = (cur_col_q & ~CW'(15)) | CW'(byte_in[3:0]);
            end else if (byte_in[7:4] == 4'h1) begin
              cur_col_d = CW'({byte_in[3:0], cur_col_q[3:0]});
            end else if (byte_in[7:3] == 5'b10110) begin
              cur_page_d = PW'(byte_in & 8'(PAGES - 1));
            end else if (byte_in == 8'h20) begin
              state_d = ST_ARG_MODE;
            end else if (byte_in == 8'h21) begin
              state_d = ST_ARG_CS;
            end else if (byte_in == 8'h22) begin
              state_d = ST_ARG_PS;
            end
          end
          ST_ARG_MODE: begin
            horiz_d = (byte_in[1:0] == 2'b00);
            state_d = ST_IDLE;
          end
          ST_ARG_CS: begin
            col_start_d = CW'(byte_in);
            state_d     = ST_ARG_CE;
          end
          ST_ARG_CE: begin
            col_end_d = CW'(byte_in);
            cur_col_d = col_start_q;
            state_d   = ST_IDLE;
          end
          ST_ARG_PS: begin
            page_start_d = PW'(byte_in & 8'(PAGES - 1));
            state_d      = ST_ARG_PE;
          end
          ST_ARG_PE: begin
            page_end_d = PW'(byte_in & 8'(PAGES - 1));
            cur_page_d = page_start_q;
            state_d    = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

`ifdef SPI_OLED_FB_MIRROR_EN
    fb_waddr = {PW'(PAGES - 1) - cur_page_q, CW'(COLS - 1) - cur_col_q};
    for (int i = 0; i < 8; i++) begin
      fb_wdata[i] = byte_in[7-i];
    end
`else
    fb_waddr = {cur_page_q, cur_col_q};
    fb_wdata = byte_in;
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_s_q     <= 2'b00;
      din_s_q      <= 2'b00;
      cs_s_q       <= 2'b11;
      cd_s_q       <= 2'b00;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      state_q      <= ST_IDLE;
      horiz_q      <= 1'b0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      cur_col_q    <= '0;
      cur_page_q   <= '0;
      wr_strobe_q  <= 1'b0;
    end else begin
      sclk_s_q     <= sclk_s_d;
      din_s_q      <= din_s_d;
      cs_s_q       <= cs_s_d;
      cd_s_q       <= cd_s_d;
      sclk_prev_q  <= sclk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      state_q      <= state_d;
      horiz_q      <= horiz_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      cur_col_q    <= cur_col_d;
      cur_page_q   <= cur_page_d;
      wr_strobe_q  <= wr_strobe_d;
    end
  end

  // Storage has no reset so it can map onto block RAM; contents survive rstb.
  always_ff @(posedge clk) begin
    if (fb_we) begin
      fb[fb_waddr] <= fb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= fb[{rd_page, rd_col}];
    end
  end

  assign rd_data   = rd_data_q;
  assign wr_strobe = wr_strobe_q;
  assign cur_col   = cur_col_q;
  assign cur_page  = cur_page_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_oled_fb.sv
`default_nettype none
// tb_spi_oled_fb: directed scenarios and randomized SPI bytes checked against a behavioural display model.
module tb_spi_oled_fb;

  localparam int COLS  = 128;
  localparam int PAGES = 8;
  localparam int CW    = 7;
  localparam int PW    = 3;

  localparam int A_NONE = 0;
  localparam int A_MODE = 1;
  localparam int A_CS   = 2;
  localparam int A_CE   = 3;
  localparam int A_PS   = 4;
  localparam int A_PE   = 5;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_din = 1'b0;
  logic          spi_cs = 1'b1;
  logic          spi_cd = 1'b0;
  logic [CW-1:0] rd_col = '0;
  logic [PW-1:0] rd_page = '0;
  logic [7:0]    rd_data;
  logic          wr_strobe;
  logic [CW-1:0] cur_col;
  logic [PW-1:0] cur_page;

  spi_oled_fb #(.COLS(COLS), .PAGES(PAGES)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .spi_clk  (spi_clk),
    .spi_din  (spi_din),
    .spi_cs   (spi_cs),
    .spi_cd   (spi_cd),
    .rd_col   (rd_col),
    .rd_page  (rd_page),
    .rd_data  (rd_data),
    .wr_strobe(wr_strobe),
    .cur_col  (cur_col),
    .cur_page (cur_page)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobes = 0;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobes <= strobes + 1;
  end

  // Behavioural display model: logical image plus cursor/window registers.
  int         m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_arg;
  bit         m_horiz;
  logic [7:0] m_fb  [PAGES][COLS];
  bit         m_vld [PAGES][COLS];

  task automatic model_reset();
    m_col = 0; m_page = 0; m_horiz = 1'b0; m_arg = A_NONE;
    m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit cd);
    int v;
    v = int'(b);
    if (cd) begin
      m_fb[m_page][m_col]  = b;
      m_vld[m_page][m_col] = 1'b1;
      if (m_horiz && m_col == m_ce) begin
        m_col  = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else begin
        m_col = (m_col + 1) % COLS;
      end
    end else begin
      case (m_arg)
        A_MODE: begin m_horiz = (v % 4 == 0); m_arg = A_NONE; end
        A_CS:   begin m_cs = v % COLS; m_arg = A_CE; end
        A_CE:   begin m_ce = v % COLS; m_col = m_cs; m_arg = A_NONE; end
        A_PS:   begin m_ps = v % PAGES; m_arg = A_PE; end
        A_PE:   begin m_pe = v % PAGES; m_page = m_ps; m_arg = A_NONE; end
        default: begin
          if (v < 16) m_col = (m_col / 16) * 16 + v;
          else if (v < 32) m_col = ((v % 16) * 16 + m_col % 16) % COLS;
          else if (v >= 'hB0 && v <= 'hB7) m_page = (v - 'hB0) % PAGES;
          else if (v == 'h20) m_arg = A_MODE;
          else if (v == 'h21) m_arg = A_CS;
          else if (v == 'h22) m_arg = A_PS;
        end
      endcase
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clock_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_din = b[i];
      tick(4);
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit cd);
    spi_cs = 1'b0;
    spi_cd = cd;
    clock_bits(b, 8);
    tick(4);
    model_byte(b, cd);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(cur_col), 32'(m_col));
    check({tag, "_page"}, 32'(cur_page), 32'(m_page));
  endtask

  // Reads a logical pixel column through the physical read port.
  task automatic check_fb(input int p, input int c, input string tag);
    logic [7:0] exp;
`ifdef SPI_OLED_FB_MIRROR_EN
    rd_page = PW'(PAGES - 1 - p);
    rd_col  = CW'(COLS - 1 - c);
    exp     = rev8(m_fb[p][c]);
`else
    rd_page = PW'(p);
    rd_col  = CW'(c);
    exp     = m_fb[p][c];
`endif
    tick(2);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [7:0] b;
    bit cd;
    model_reset();
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++) begin m_vld[p][c] = 1'b0; m_fb[p][c] = 8'h00; end

    // Reset state
    tick(3);
    check("rst_strobe", 32'(wr_strobe), 0);
    check("rst_col", 32'(cur_col), 0);
    check("rst_page", 32'(cur_page), 0);
    check("rst_rd", 32'(rd_data), 0);
    rstb = 1'b1;
    tick(3);

    // Column/page commands then one data byte
    s0 = strobes;
    spi_byte(8'hB2, 0); spi_byte(8'h13, 0); spi_byte(8'h05, 0);
    spi_byte(8'hA5, 1);
    check("basic_strobes", 32'(strobes - s0), 1);
    check("basic_col", 32'(cur_col), 32'h36);
    check("basic_page", 32'(cur_page), 2);
    check_fb(2, 'h35, "basic_fb");

    // Page mode wrap of the last column
    spi_byte(8'h0F, 0); spi_byte(8'h17, 0);
    spi_byte(8'h11, 1); spi_byte(8'h22, 1);
    check("wrap_col", 32'(cur_col), 1);
    check("wrap_page", 32'(cur_page), 2);
    check_fb(2, 127, "wrap_fb127");
    check_fb(2, 0, "wrap_fb0");

    // Horizontal mode inside a column/page window
    spi_byte(8'h20, 0); spi_byte(8'h00, 0);
    spi_byte(8'h21, 0); spi_byte(8'd10, 0); spi_byte(8'd12, 0);
    spi_byte(8'h22, 0); spi_byte(8'd1, 0); spi_byte(8'd2, 0);
    for (int i = 0; i < 7; i++) spi_byte(8'h60 + 8'(i), 1);
    check("win_col", 32'(cur_col), 11);
    check("win_page", 32'(cur_page), 1);
    for (int p = 1; p <= 2; p++)
      for (int c = 10; c <= 12; c++) check_fb(p, c, "win_fb");

    // Partial byte discarded by deselect
    s0 = strobes;
    spi_cs = 1'b0; spi_cd = 1'b1;
    clock_bits(8'hFF, 5);
    spi_cs = 1'b1;
    tick(6);
    spi_byte(8'h3C, 1);
    check("partial_strobes", 32'(strobes - s0), 1);
    check_fb(1, 11, "partial_fb");
    check_cursor("partial");

    // Randomized command/data mix
    for (int n = 0; n < 80; n++) begin
      cd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 8'($urandom_range(0, 31));
        1: b = 8'hB0 + 8'($urandom_range(0, 7));
        2: b = 8'h20;
        3: b = 8'h21;
        4: b = 8'h22;
        default: b = 8'($urandom);
      endcase
      if (cd) b = 8'($urandom);
      spi_byte(b, cd);
      if ($urandom_range(0, 7) == 0) begin spi_cs = 1'b1; tick(4); end
      check_cursor("rand");
    end

    // Reset in the middle of a data byte
    s0 = strobes;
    spi_cs = 1'b0; spi_cd = 1'b1;
    clock_bits(8'hC3, 5);
    spi_din = 1'b1;
    spi_clk = 1'b1;
    tick(1);
    rstb = 1'b0;
    tick(3);
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    tick(2);
    rstb = 1'b1;
    model_reset();
    tick(4);
    check("midrst_strobes", 32'(strobes - s0), 0);
    check("midrst_col", 32'(cur_col), 0);
    check("midrst_page", 32'(cur_page), 0);
    for (int p = 0; p < PAGES; p++)
      for (int c = 0; c < COLS; c++)
        if (m_vld[p][c]) check_fb(p, c, "keep_fb");

    // Single pixel at the origin (mirrored build reads it back at the far corner)
    spi_byte(8'h00, 0); spi_byte(8'h10, 0); spi_byte(8'hB0, 0);
    spi_byte(8'h01, 1);
    check_fb(0, 0, "origin_fb");
    check_cursor("origin");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
